e16_pulse2toggle_credit: RTL and testbench



---
 rtl/e16_pulse2toggle_credit.sv | 95 +++++++++
 tb/tb_e16_pulse2toggle_credit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/e16_pulse2toggle_credit.sv
// Multi-channel pulse-to-toggle converter with optional per-channel credit handshake.
// In handshake mode, pulses that arrive while a toggle is unacknowledged are held in a saturating counter.
module e16_pulse2toggle_credit #(
    parameter int CH      = 4,
    parameter int CW      = 3,
    parameter int ACKWAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH-1:0]     in,
    input  logic [CH-1:0]     ack,
    input  logic [CH-1:0]     clr_ovf,
    output logic [CH-1:0]     out,
    output logic [CH-1:0]     busy,
    output logic [CH*CW-1:0]  pend,
    output logic [CH-1:0]     ovf
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic [CH-1:0]    out_q;
    logic [CH-1:0]    out_d;
    logic [CH-1:0]    ovf_q;
    logic [CH-1:0]    ovf_d;
    logic [CH*CW-1:0] pend_q;
    logic [CH*CW-1:0] pend_d;
    logic [CH-1:0]    busy_s;

    // A toggle is outstanding until the receiver's returned toggle catches up with out.
    assign busy_s = (ACKWAIT != 0) ? (out_q ^ ack) : {CH{1'b0}};

    assign out  = out_q;
    assign busy = busy_s;
    assign pend = pend_q;
    assign ovf  = ovf_q;

    // Per-channel next state: launch a queued or fresh event when idle, otherwise queue it.
    always_comb begin
        logic [CW-1:0] cnt_v;
        logic          launch_v;
        logic          set_v;
        out_d    = out_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        cnt_v    = CNT_ZERO;
        launch_v = 1'b0;
        set_v    = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (ACKWAIT == 0) begin
                out_d[i]             = out_q[i] ^ in[i];
                pend_d[i*CW +: CW]   = CNT_ZERO;
                ovf_d[i]             = 1'b0;
            end else begin
                cnt_v    = pend_q[i*CW +: CW];
                set_v    = 1'b0;
                launch_v = (in[i] || (cnt_v != CNT_ZERO)) && !busy_s[i];
                if (launch_v) begin
                    out_d[i] = ~out_q[i];
                    // A fresh pulse replaces the consumed queued event, so the count only drops without one.
                    if (!in[i]) begin
                        cnt_v = cnt_v - CNT_ONE;
                    end else begin
                        cnt_v = cnt_v;
                    end
                end else if (in[i]) begin
                    if (cnt_v == CNT_MAX) begin
                        set_v = 1'b1;
                    end else begin
                        cnt_v = cnt_v + CNT_ONE;
                    end
                end else begin
                    cnt_v = cnt_v;
                end
                pend_d[i*CW +: CW] = cnt_v;
                ovf_d[i]           = set_v | (ovf_q[i] & ~clr_ovf[i]);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= {CH{1'b0}};
            pend_q <= {(CH*CW){1'b0}};
            ovf_q  <= {CH{1'b0}};
        end else begin
            out_q  <= out_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_e16_pulse2toggle_credit.sv
// Directed bench for e16_pulse2toggle_credit: handshake instance plus a free-running instance,
// checked every cycle against an event-count model and at key points against literal values.
module tb_e16_pulse2toggle_credit;

    localparam int MAXP = 7;

    logic       clk;
    logic       reset;
    logic [3:0] in_s;
    logic [3:0] ack_s;
    logic [3:0] clr_s;
    logic [3:0] in0_s;
    logic [3:0] zero4;

    logic [3:0]  out;
    logic [3:0]  busy;
    logic [11:0] pend;
    logic [3:0]  ovf;
    logic [3:0]  out0;
    logic [3:0]  busy0;
    logic [11:0] pend0;
    logic [3:0]  ovf0;

    int n_chk = 0;
    int n_err = 0;

    e16_pulse2toggle_credit #(.CH(4), .CW(3), .ACKWAIT(1)) dut (
        .clk(clk), .reset(reset), .in(in_s), .ack(ack_s), .clr_ovf(clr_s),
        .out(out), .busy(busy), .pend(pend), .ovf(ovf)
    );

    e16_pulse2toggle_credit #(.CH(4), .CW(3), .ACKWAIT(0)) dut0 (
        .clk(clk), .reset(reset), .in(in0_s), .ack(zero4), .clr_ovf(zero4),
        .out(out0), .busy(busy0), .pend(pend0), .ovf(ovf0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: each channel owns a count of waiting events; one is sent whenever the receiver has caught up.
    logic [3:0] m_out  = 4'd0;
    logic [3:0] m_ovf  = 4'd0;
    logic [3:0] m_pend [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] m0_out = 4'd0;

    function automatic logic [5:0] model_next(input logic [3:0] p, input logic o, input logic v,
                                              input logic i_b, input logic a_b, input logic c_b);
        int   total;
        int   np;
        logic no;
        logic set;
        total = int'(p) + int'(i_b);
        np    = total;
        no    = o;
        set   = 1'b0;
        if ((o == a_b) && (total > 0)) begin
            no = ~o;
            np = total - 1;
        end else if (total > MAXP) begin
            np  = MAXP;
            set = 1'b1;
        end
        return {set | (v & ~c_b), no, 4'(np)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out  <= 4'd0;
            m_ovf  <= 4'd0;
            m0_out <= 4'd0;
            for (int i = 0; i < 4; i++) m_pend[i] <= 4'd0;
        end else begin
            m0_out <= m0_out ^ in0_s;
            for (int i = 0; i < 4; i++)
                {m_ovf[i], m_out[i], m_pend[i]} <= model_next(m_pend[i], m_out[i], m_ovf[i],
                                                              in_s[i], ack_s[i], clr_s[i]);
        end
    end

    logic [11:0] exp_pend;
    always_comb begin
        exp_pend = 12'd0;
        for (int i = 0; i < 4; i++) exp_pend[i*3 +: 3] = m_pend[i][2:0];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_out",   32'(out),   32'(m_out));
        chk("cyc_busy",  32'(busy),  32'(m_out ^ ack_s));
        chk("cyc_pend",  32'(pend),  32'(exp_pend));
        chk("cyc_ovf",   32'(ovf),   32'(m_ovf));
        chk("cyc0_out",  32'(out0),  32'(m0_out));
        chk("cyc0_busy", 32'(busy0), 32'd0);
        chk("cyc0_pend", 32'(pend0), 32'd0);
        chk("cyc0_ovf",  32'(ovf0),  32'd0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        in_s  = 4'd0;
        ack_s = 4'd0;
        clr_s = 4'd0;
        in0_s = 4'd0;
        zero4 = 4'd0;
        #1 reset = 1'b1;
        #1;
        chk("rst_out",  32'(out),  32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        step();
        reset = 1'b0;

        // Single pulse on idle channel 0, receiver answers after three busy cycles.
        in_s[0] = 1'b1;
        step();
        in_s[0] = 1'b0;
        #1;
        chk("t1_out0",   32'(out[0]),   32'd1);
        chk("t1_busy0a", 32'(busy[0]),  32'd1);
        chk("t1_pend0",  32'(pend[2:0]), 32'd0);
        step();
        chk("t1_busy0b", 32'(busy[0]),  32'd1);
        step();
        chk("t1_busy0c", 32'(busy[0]),  32'd1);
        ack_s[0] = 1'b1;
        #1;
        chk("t1_busy0d", 32'(busy[0]),  32'd0);

        // Channel 1: queue three events behind an unacknowledged toggle, then drain back-to-back.
        in_s[1] = 1'b1;
        step();
        repeat (3) step();
        in_s[1] = 1'b0;
        #1;
        chk("t2_pend3", 32'(pend[5:3]), 32'd3);
        chk("t2_out1",  32'(out[1]),    32'd1);
        ack_s[1] = 1'b1;
        #1;
        chk("t2_busy_clr", 32'(busy[1]), 32'd0);
        step();
        chk("t2_out_a",  32'(out[1]),    32'd0);
        chk("t2_pend2",  32'(pend[5:3]), 32'd2);
        ack_s[1] = 1'b0;
        step();
        chk("t2_out_b",  32'(out[1]),    32'd1);
        chk("t2_pend1",  32'(pend[5:3]), 32'd1);
        ack_s[1] = 1'b1;
        step();
        chk("t2_out_c",  32'(out[1]),    32'd0);
        chk("t2_pend0",  32'(pend[5:3]), 32'd0);
        ack_s[1] = 1'b0;
        step();
        chk("t2_idle",   32'(out[1]),    32'd0);

        // Channel 2: overflow, set beating clear, then clear alone.
        in_s[2] = 1'b1;
        step();
        repeat (7) step();
        chk("t3_pend7", 32'(pend[8:6]), 32'd7);
        chk("t3_novf",  32'(ovf[2]),    32'd0);
        step();
        chk("t3_pend_sat", 32'(pend[8:6]), 32'd7);
        chk("t3_ovf",      32'(ovf[2]),    32'd1);
        clr_s[2] = 1'b1;
        step();
        chk("t3_set_wins", 32'(ovf[2]), 32'd1);
        in_s[2] = 1'b0;
        step();
        chk("t3_cleared", 32'(ovf[2]), 32'd0);
        clr_s[2] = 1'b0;

        // Channel 3: ack match coinciding with a fresh pulse keeps the count.
        in_s[3] = 1'b1;
        step();
        step();
        step();
        chk("t4_pend2a", 32'(pend[11:9]), 32'd2);
        ack_s[3] = 1'b1;
        step();
        in_s[3] = 1'b0;
        chk("t4_out3",   32'(out[3]),     32'd0);
        chk("t4_pend2b", 32'(pend[11:9]), 32'd2);

        // Free-running instance: pattern held two cycles toggles out and back.
        in0_s = 4'b1010;
        #1;
        chk("t5_out_a", 32'(out0), 32'h0);
        step();
        chk("t5_out_b", 32'(out0), 32'hA);
        step();
        chk("t5_out_c", 32'(out0), 32'h0);
        in0_s = 4'd0;

        // Channel 0: receiver flips ack unprompted, five events queue, then reset mid-burst.
        ack_s[0] = 1'b0;
        #1;
        chk("t6_violation_busy", 32'(busy[0]), 32'd1);
        in_s[0] = 1'b1;
        repeat (5) step();
        in_s[0] = 1'b0;
        #1;
        chk("t6_pend5", 32'(pend[2:0]), 32'd5);
        chk("t6_out1",  32'(out[0]),    32'd1);
        reset = 1'b1;
        ack_s = 4'd0;
        #1;
        chk("t6_rst_out",  32'(out),  32'd0);
        chk("t6_rst_pend", 32'(pend), 32'd0);
        chk("t6_rst_ovf",  32'(ovf),  32'd0);
        step();
        step();
        reset = 1'b0;
        in_s[0] = 1'b1;
        step();
        in_s[0] = 1'b0;
        #1;
        chk("t6_after_out",  32'(out[0]),    32'd1);
        chk("t6_after_pend", 32'(pend[2:0]), 32'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
